// File: rtl/wb_sample_fifo.sv
// Wishbone sample FIFO (CTRL/STATUS/DATA/THRESH) with threshold irq; define TIMESTAMP_EN to tag each sample with a 16-bit timestamp.
// Ack is a 1-cycle pulse one cycle after a hit; samples are never back-pressured, so a push into a full FIFO is dropped and flagged.
module wb_sample_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DW        = 12
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          sample_valid_i,
  input  logic [DW-1:0] sample_data_i,
  output logic          irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DATA   = 2'd2;
  localparam logic [1:0] OFF_THRESH = 2'd3;

  logic          hit;
  logic          ack_q, ack_d;
  logic [1:0]    off_q, off_d;
  logic          we_q, we_d;
  logic          sel0_q, sel0_d;
  logic [8:0]    wdat_q, wdat_d;
  logic          enable_q, enable_d;
  logic [4:0]    thresh_q, thresh_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          irq_q, irq_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          wr_en, ctrl_wr, stat_wr, thr_wr, flush;
  logic          full, empty, push, pop, drop;
  logic [31:0]   head_word;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);

  // Request fields are captured on the hit so the ack cycle acts on a stable copy.
  always_comb begin
    ack_d  = hit & ~ack_q;
    off_d  = off_q;
    we_d   = we_q;
    sel0_d = sel0_q;
    wdat_d = wdat_q;
    if (ack_d) begin
      off_d  = wbs_adr_i[3:2];
      we_d   = wbs_we_i;
      sel0_d = wbs_sel_i[0];
      wdat_d = wbs_dat_i[8:0];
    end
  end

  assign wr_en   = ack_q & we_q & sel0_q;
  assign ctrl_wr = wr_en & (off_q == OFF_CTRL);
  assign stat_wr = wr_en & (off_q == OFF_STATUS);
  assign thr_wr  = wr_en & (off_q == OFF_THRESH);
  assign flush   = ctrl_wr & wdat_q[1];

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = ack_q & ~we_q & (off_q == OFF_DATA) & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = sample_valid_i & enable_q & (~full | pop);
  assign drop  = sample_valid_i & enable_q & full & ~pop;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    enable_d   = ctrl_wr ? wdat_q[0] : enable_q;
    thresh_d   = thr_wr ? wdat_q[4:0] : thresh_q;
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push & ~pop)      count_d = count_q + (AW+1)'(1);
      else if (pop & ~push) count_d = count_q - (AW+1)'(1);
      if (stat_wr & wdat_q[8]) overflow_d = 1'b0;
      if (drop)                overflow_d = 1'b1;
    end
    irq_d = enable_q & (thresh_q != 5'd0) & (32'(count_q) >= 32'(thresh_q));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q      <= 1'b0;
      off_q      <= 2'd0;
      we_q       <= 1'b0;
      sel0_q     <= 1'b0;
      wdat_q     <= '0;
      enable_q   <= 1'b0;
      thresh_q   <= '0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      off_q      <= off_d;
      we_q       <= we_d;
      sel0_q     <= sel0_d;
      wdat_q     <= wdat_d;
      enable_q   <= enable_d;
      thresh_q   <= thresh_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wptr_q] <= sample_data_i;
  end

`ifdef TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_mem_q [DEPTH];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) ts_q <= 16'd0;
    else           ts_q <= ts_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) ts_mem_q[wptr_q] <= ts_q;
  end

  assign head_word = {ts_mem_q[rptr_q], 4'b0, 12'(mem_q[rptr_q])};
`else
  assign head_word = {20'b0, 12'(mem_q[rptr_q])};
`endif

  // Data bus is only driven on read acks; everything else reads as zero.
  always_comb begin
    rdata = '0;
    if (ack_q & ~we_q) begin
      case (off_q)
        OFF_CTRL:   rdata[0] = enable_q;
        OFF_STATUS: begin
          rdata[20:16] = 5'(count_q);
          rdata[8]     = overflow_q;
          rdata[1]     = full;
          rdata[0]     = empty;
        end
        OFF_DATA:   if (!empty) rdata = head_word;
        OFF_THRESH: rdata[4:0] = thresh_q;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata;
  assign irq_o     = irq_q;

  assign unused_ok = &{1'b0, wbs_dat_i[31:9], wbs_sel_i[3:1], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_wb_sample_fifo.sv
// Directed bench for wb_sample_fifo: register vector table plus hand-written FIFO, irq, flush and reset sequences.
module tb_wb_sample_fifo;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [1:0] CTRL = 2'd0, STATUS = 2'd1, DATA = 2'd2, THRESH = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        svld;
  logic [11:0] sdat;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic [1:0]  off;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [15];

  always #5 clk = ~clk;

  wb_sample_fifo #(.BASE_ADDR(BASE), .DEPTH(16), .DW(12)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .sample_valid_i(svld), .sample_data_i(sdat),
    .irq_o(irq)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends 1 time unit after a rising edge; the access has committed on return.
  task automatic wb_xfer(input logic w, input logic [1:0] off, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] r);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; wdat = d;
    adr = BASE | {28'h0, off, 2'b00};
    n = 0;
    do begin
      step();
      n++;
    end while (ack !== 1'b1 && n < 8);
    if (ack !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: ack=%b after %0d cycles, required 1", ack, n);
    end
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, off, 4'hF, d, r);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, off, 4'hF, 32'h0, r);
    chk(name, r, exp);
  endtask

  task automatic push_seq(input logic [11:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      svld = 1'b1;
      sdat = first + 12'(i);
      step();
    end
    svld = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [5:0]  pat;
    int          nack;

    vt[0]  = '{1'b0, CTRL,   4'hF, 32'h0,         32'h0};
    vt[1]  = '{1'b0, STATUS, 4'hF, 32'h0,         32'h1};
    vt[2]  = '{1'b0, THRESH, 4'hF, 32'h0,         32'h0};
    vt[3]  = '{1'b0, DATA,   4'hF, 32'h0,         32'h0};
    vt[4]  = '{1'b1, THRESH, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vt[5]  = '{1'b0, THRESH, 4'hF, 32'h0,         32'h1F};
    vt[6]  = '{1'b1, THRESH, 4'hE, 32'h0000_0003, 32'h0};
    vt[7]  = '{1'b0, THRESH, 4'hF, 32'h0,         32'h1F};
    vt[8]  = '{1'b1, CTRL,   4'h1, 32'h0000_0001, 32'h0};
    vt[9]  = '{1'b0, CTRL,   4'hF, 32'h0,         32'h1};
    vt[10] = '{1'b1, CTRL,   4'hF, 32'h0000_0000, 32'h0};
    vt[11] = '{1'b0, CTRL,   4'hF, 32'h0,         32'h0};
    vt[12] = '{1'b1, THRESH, 4'hF, 32'h0,         32'h0};
    vt[13] = '{1'b0, THRESH, 4'hF, 32'h0,         32'h0};
    vt[14] = '{1'b0, STATUS, 4'hF, 32'h0,         32'h1};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; wdat = 32'h0; svld = 1'b0; sdat = 12'h0;
    #12;
    chk("reset_ack", {31'b0, ack}, 32'h0);
    chk("reset_dat", rdat, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      wb_xfer(vt[i].we, vt[i].off, vt[i].sel, vt[i].wdat, r);
      if (!vt[i].we) chk($sformatf("vec%0d", i), r, vt[i].exp);
    end

    // Out-of-window address and missing cyc must never be acked.
    nack = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10;
    for (int i = 0; i < 4; i++) begin step(); if (ack) nack++; end
    cyc = 1'b0; adr = BASE;
    for (int i = 0; i < 3; i++) begin step(); if (ack) nack++; end
    stb = 1'b0;
    chk("nonhit_acks", 32'(nack), 32'h0);

    // Held strobe: ack on every other cycle.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h4;
    for (int i = 0; i < 6; i++) begin step(); pat[i] = ack; end
    cyc = 1'b0; stb = 1'b0;
    step();
    chk("b2b_ack_pattern", {26'b0, pat}, 32'h15);
    chk("idle_dat_zero", rdat, 32'h0);

    // Disabled FIFO ignores samples.
    push_seq(12'h0AA, 1);
    rd_chk("disabled_status", STATUS, 32'h1);

    // Basic in-order readout and empty read.
    wr(CTRL, 32'h1);
    push_seq(12'h001, 3);
    rd_chk("basic_rd0", DATA, 32'h1);
    rd_chk("basic_rd1", DATA, 32'h2);
    rd_chk("basic_rd2", DATA, 32'h3);
    rd_chk("empty_rd", DATA, 32'h0);
    rd_chk("empty_status", STATUS, 32'h1);

    // Threshold interrupt timing.
    wr(THRESH, 32'h4);
    push_seq(12'h010, 3);
    step();
    chk("irq_below_thresh", {31'b0, irq}, 32'h0);
    push_seq(12'h013, 1);
    chk("irq_not_early", {31'b0, irq}, 32'h0);
    step();
    chk("irq_at_thresh", {31'b0, irq}, 32'h1);
    rd_chk("irq_rd", DATA, 32'h10);
    step();
    chk("irq_after_pop", {31'b0, irq}, 32'h0);
    rd_chk("irq_drain0", DATA, 32'h11);
    rd_chk("irq_drain1", DATA, 32'h12);
    rd_chk("irq_drain2", DATA, 32'h13);
    wr(THRESH, 32'h0);

    // Overflow: 17 pushes into 16 entries, pointers wrap.
    push_seq(12'h001, 17);
    rd_chk("ovf_status", STATUS, 32'h0010_0102);
    for (int i = 1; i <= 16; i++) rd_chk($sformatf("ovf_rd%0d", i), DATA, 32'(i));
    rd_chk("ovf_status_empty", STATUS, 32'h0000_0101);
    wr(STATUS, 32'h100);
    rd_chk("ovf_cleared", STATUS, 32'h1);

    // Push and pop in the same cycle while full.
    push_seq(12'h200, 16);
    rd_chk("full_status", STATUS, 32'h0010_0002);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE | 32'h8;
    step();
    chk("simul_ack", {31'b0, ack}, 32'h1);
    chk("simul_head", rdat, 32'h200);
    svld = 1'b1; sdat = 12'h2AA;
    cyc = 1'b0; stb = 1'b0;
    step();
    svld = 1'b0;
    rd_chk("simul_status", STATUS, 32'h0010_0002);
    for (int i = 1; i < 16; i++) rd_chk($sformatf("simul_rd%0d", i), DATA, 32'h200 + 32'(i));
    rd_chk("simul_tail", DATA, 32'h2AA);
    rd_chk("simul_empty", STATUS, 32'h1);

    // Flush beats a concurrent push and clears overflow.
    push_seq(12'h301, 17);
    rd_chk("fl_rd0", DATA, 32'h301);
    rd_chk("fl_rd1", DATA, 32'h302);
    rd_chk("fl_rd2", DATA, 32'h303);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE; wdat = 32'h3;
    svld = 1'b1; sdat = 12'h055;
    step();
    chk("flush_ack", {31'b0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
    svld = 1'b0;
    rd_chk("flush_status", STATUS, 32'h1);
    rd_chk("flush_ctrl", CTRL, 32'h1);
    rd_chk("flush_data", DATA, 32'h0);

    // Reset during a pending hit.
    wr(THRESH, 32'h1);
    push_seq(12'h007, 1);
    step();
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h4;
    #3;
    rst_n = 1'b0;
    step();
    chk("rst_mid_ack", {31'b0, ack}, 32'h0);
    chk("rst_mid_dat", rdat, 32'h0);
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd_chk("post_rst_status", STATUS, 32'h1);
    rd_chk("post_rst_ctrl", CTRL, 32'h0);
    rd_chk("post_rst_thresh", THRESH, 32'h0);
    rd_chk("post_rst_data", DATA, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
